// File: rtl/rv_pkg.sv
// Shared RV32 core definitions: word width, NOP encoding, reset PC,
// fetch FSM states and the IF/ID pipeline record.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            misaligned;
  } if_id_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ROM port, redirect from execute, IF/ID handshake to
// decode, consumed-slot counter and FSM state for observation.
//
// Handshake: out_valid means the IF/ID slot holds an instruction; decode
// takes it on any rising edge where out_valid & out_ready. While out_valid
// is high and out_ready is low, out_inst/out_pc/out_misaligned stay stable
// unless a redirect squashes the slot. out_valid does not depend
// combinationally on out_ready.
interface inst_fetch_if;
  import rv_pkg::*;

  logic [XLEN-1:0] rom_addr;
  logic [XLEN-1:0] rom_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_misaligned;
  logic [XLEN-1:0] fetch_count;
  fetch_state_t    state;

  modport master (
    output rom_addr, out_valid, out_inst, out_pc, out_misaligned,
           fetch_count, state,
    input  rom_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, out_inst, out_pc, out_misaligned,
           fetch_count, state,
    output rom_data, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/inst_fetch_if_id_slot.sv
// One-entry valid/ready pipeline register with flush. Priority:
// flush > load > drain-on-ready > hold. 'advance' tells the producer the
// slot can take a new entry this cycle (empty, or being consumed).
module if_id_slot
  import rv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   load,
  input  if_id_t in_data,
  input  logic   ready,
  output logic   valid,
  output if_id_t data,
  output logic   advance
);

  localparam if_id_t RESET_ENTRY = '{inst: NOP_INST, pc: '0, misaligned: 1'b0};

  assign advance = !valid || ready;

  // Valid flag: flush squashes, load fills, consumption empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  // Payload only changes on a load, so a held or squashed slot keeps its fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= RESET_ENTRY;
    end else if (!flush && load) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, addresses the combinational ROM, fills
// the IF/ID slot, takes redirects from execute and traps misaligned targets.
module inst_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)(
  input  logic        clk,
  input  logic        rst,
  inst_fetch_if.master bus
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] count;
  fetch_state_t    state;
  fetch_state_t    state_next;
  logic            load;
  logic            pc_misaligned;
  logic            slot_valid;
  logic            advance;
  logic            fire;
  if_id_t          slot_in;
  if_id_t          slot_out;

  assign pc_misaligned = (pc[1:0] != 2'b00);
  assign fire          = slot_valid && bus.out_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: redirect always resumes; a misaligned fetch parks in FAULT.
  always_comb begin
    state_next = state;
    if (bus.redirect_valid) begin
      state_next = RUN;
    end else if (state == RUN && advance && pc_misaligned) begin
      state_next = FAULT;
    end
  end

  // FSM outputs: slot load, slot payload and the next PC.
  always_comb begin
    load    = (state == RUN) && advance && !bus.redirect_valid;
    slot_in = '{inst: bus.rom_data, pc: pc, misaligned: 1'b0};
    pc_next = pc;
    if (pc_misaligned) begin
      slot_in = '{inst: NOP_INST, pc: pc, misaligned: 1'b1};
    end
    if (bus.redirect_valid) begin
      pc_next = bus.redirect_pc;
    end else if (load && !pc_misaligned) begin
      pc_next = pc + 32'd4;
    end
  end

  // Program counter; a faulted PC holds until redirected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Consumed-slot counter; a fire coinciding with a redirect still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (fire) begin
      count <= count + 32'd1;
    end
  end

  if_id_slot u_slot (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.redirect_valid),
    .load    (load),
    .in_data (slot_in),
    .ready   (bus.out_ready),
    .valid   (slot_valid),
    .data    (slot_out),
    .advance (advance)
  );

  assign bus.rom_addr       = pc;
  assign bus.out_valid      = slot_valid;
  assign bus.out_inst       = slot_out.inst;
  assign bus.out_pc         = slot_out.pc;
  assign bus.out_misaligned = slot_out.misaligned;
  assign bus.fetch_count    = count;
  assign bus.state          = state;

endmodule
